quad_decoder: RTL and testbench
===============================

Name: quad_decoder

Overview:
- Quadrature (A/B phase) decoder that generates the up/down direction and count-step events an up/down counter consumes.
- Keeps its own position counter.
- Sits between an external incremental encoder (asynchronous pins) and the counter/position logic in the clock domain.
- Synchronises the phases, decodes the Gray sequence into step/dir pulses, tracks position, and flags illegal transitions.

Parameters:
- WIDTH, 8, width of position counter `count` (wraps modulo 2^WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- qa  input  1  encoder phase A, asynchronous to clk.
- qb  input  1  encoder phase B, asynchronous to clk.
- err_clr  input  1  synchronous clear of sticky err_flag.
- step  output  1  one-cycle pulse per valid quadrature edge.
- up_down  output  1  direction of last valid step: 1 = up, 0 = down. Holds between steps.
- count  output  WIDTH  signed-agnostic position counter.
- err_pulse  output  1  one-cycle pulse on illegal transition (both phases changed).
- err_flag  output  1  sticky error indicator.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values:
  - Sync flops 0, prev_ab 2'b00, state INIT, init counter 0.
  - step 0, up_down 1, count 0, err_pulse 0, err_flag 0.
- Synchroniser: two flop stages per phase (s1, s2). Decode uses s2 only.
- Latency: an input change settling before edge n appears in s2 after edge n+1. step/up_down/count/err update at edge n+2.
- State machine:
  - INIT: entered on reset. Stays 2 cycles after reset deasserts (pipeline fill). On the 3rd edge, prev_ab <= s2 pair, then go to TRACK. No step/err in INIT.
  - TRACK: each edge compares cur = {qa_s2,qb_s2} with prev_ab, then prev_ab <= cur.
- Decode in TRACK:
  - Forward sequence 00->01->11->10->00: step=1, up_down<=1, count<=count+1.
  - Reverse sequence 00->10->11->01->00: step=1, up_down<=0, count<=count-1.
  - cur == prev: step=0, count and up_down hold.
  - Both bits differ (00<->11, 01<->10): err_pulse=1, err_flag<=1, step=0, count and up_down hold. prev_ab still takes cur (resynchronise).
- Wrap-around: count is modulo 2^WIDTH. All-ones +1 -> 0; 0 -1 -> all-ones. No saturation, no flag.
- err_clr:
  - Clears err_flag at the next edge.
  - If an illegal transition is detected in the same cycle, set wins: err_flag stays 1 and err_pulse=1.
  - err_clr has no effect on count.
- Reset mid-operation: reset overrides everything in that cycle. All outputs take reset values at that edge and the block re-enters INIT.
- Rate limit: decode is correct only if each phase is stable for at least 1 clk after synchronisation, i.e. encoder edge spacing ≥ 2 clk. Faster inputs may produce err_pulse; this is the intended detection.

Decomposition:
- Package quad_pkg:
  - Phase constants PH_00, PH_01, PH_11, PH_10.
  - State encoding ST_INIT, ST_TRACK.
  - Function returning {valid, dir, illegal} from (prev, cur).
- Sub-module quad_sync: parameterless 2-flop synchroniser with synchronous active-high reset. Instantiated once per phase.
- Top quad_decoder contains the FSM, init counter, decode and counter.

Test Plan:
- Reset, qa=qb=0, release reset, 3 cycles idle -> state TRACK, count=0, step never 1, up_down=1, err_flag=0.
- WIDTH=8; apply forward sequence 01,11,10,00 twice, each held 4 clk -> 8 step pulses; each step lands 3 clk after its input change; up_down=1, final count=8.
- From count=2, apply reverse 10,11,01,00,10,11 -> 6 steps, up_down=0, count wraps to 8'hFC.
- Hold qa=qb=1 through reset release -> INIT loads prev=11, no err_pulse. Then 11->00 -> err_pulse once, err_flag=1, count unchanged. Assert err_clr together with a new 00->11 jump -> err_flag remains 1. err_clr alone next -> err_flag=0.
- Mid-sequence (count=5) assert reset for 1 clk -> at that edge count=0, step=0, up_down=1. Following forward steps are ignored until INIT completes (2 cycles), then count resumes from 0.
- WIDTH=2: 5 forward steps -> count goes 1,2,3,0,1.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: phase encodings, FSM states
// and the Gray-code transition classifier.
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // Edges spent in INIT after reset release before the phase pair is trusted.
  localparam logic [1:0] INIT_CYCLES = 2'd2;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Classifies a phase transition; result is {valid, dir, illegal}, dir 1 = up.
  function automatic logic [2:0] decode_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [2:0] res;
    res = 3'b000;
    case ({prev, cur})
      {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: res = 3'b110;
      {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}: res = 3'b100;
      {PH_00, PH_11}, {PH_11, PH_00}, {PH_01, PH_10}, {PH_10, PH_01}: res = 3'b001;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/quad_sync.sv
// Two-flop synchroniser for one asynchronous encoder phase.
// Only the second stage is meant to be consumed downstream.
module quad_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_r;
  logic s2_r;

  // Metastability filter: s1 may go metastable, s2 is the settled copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  assign q = s2_r;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises A/B, decodes Gray transitions into step/dir
// pulses, keeps a wrapping position counter and flags illegal double changes.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             qa,
  input  logic             qb,
  input  logic             err_clr,
  output logic             step,
  output logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             err_pulse,
  output logic             err_flag
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic             qa_s2_s;
  logic             qb_s2_s;
  logic [1:0]       cur_s;
  logic [2:0]       dec_s;
  logic             load_prev_s;
  logic             track_s;
  logic             valid_s;
  logic             illegal_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [1:0]       init_cnt_r;
  logic [1:0]       prev_r;
  logic             step_r;
  logic             up_down_r;
  logic [WIDTH-1:0] count_r;
  logic             err_pulse_r;
  logic             err_flag_r;

  quad_sync u_sync_a (.clk(clk), .reset(reset), .d(qa), .q(qa_s2_s));
  quad_sync u_sync_b (.clk(clk), .reset(reset), .d(qb), .q(qb_s2_s));

  assign cur_s = {qa_s2_s, qb_s2_s};

  // Next-state and decode qualification; nothing is decoded while INIT fills the pipeline.
  always_comb begin
    state_nxt_s = state_r;
    load_prev_s = 1'b0;
    track_s     = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (init_cnt_r == INIT_CYCLES) begin
          state_nxt_s = ST_TRACK;
          load_prev_s = 1'b1;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_TRACK: begin
        state_nxt_s = ST_TRACK;
        track_s     = 1'b1;
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
    dec_s     = decode_step(prev_r, cur_s);
    valid_s   = track_s & dec_s[2];
    illegal_s = track_s & dec_s[0];
  end

  // FSM state, init counter and previous phase pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_INIT;
      init_cnt_r <= 2'd0;
      prev_r     <= PH_00;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_INIT) && (init_cnt_r != INIT_CYCLES)) begin
        init_cnt_r <= init_cnt_r + 2'd1;
      end else begin
        init_cnt_r <= init_cnt_r;
      end
      // An illegal jump still resynchronises prev to the observed pair.
      if (load_prev_s || track_s) begin
        prev_r <= cur_s;
      end else begin
        prev_r <= prev_r;
      end
    end
  end

  // Registered step/direction/position and error outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_r      <= 1'b0;
      up_down_r   <= 1'b1;
      count_r     <= '0;
      err_pulse_r <= 1'b0;
      err_flag_r  <= 1'b0;
    end else begin
      step_r      <= valid_s;
      err_pulse_r <= illegal_s;
      if (valid_s) begin
        up_down_r <= dec_s[1];
        count_r   <= dec_s[1] ? (count_r + CNT_ONE) : (count_r - CNT_ONE);
      end else begin
        up_down_r <= up_down_r;
        count_r   <= count_r;
      end
      if (illegal_s) begin
        err_flag_r <= 1'b1;
      end else if (err_clr) begin
        err_flag_r <= 1'b0;
      end else begin
        err_flag_r <= err_flag_r;
      end
    end
  end

  assign step      = step_r;
  assign up_down   = up_down_r;
  assign count     = count_r;
  assign err_pulse = err_pulse_r;
  assign err_flag  = err_flag_r;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder (WIDTH=8 and WIDTH=2 instances) using a
// per-cycle scoreboard fed by an independent position-index reference model.
module tb_quad_decoder;
  import quad_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       qa = 1'b0;
  logic       qb = 1'b0;
  logic       err_clr = 1'b0;

  logic       step, up_down, err_pulse, err_flag;
  logic [7:0] count;
  logic       step2, up_down2, err_pulse2, err_flag2;
  logic [1:0] count2;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic       step;
    logic       up_down;
    logic [7:0] count;
    logic       err_pulse;
    logic       err_flag;
  } exp_t;

  exp_t sb_q[$];

  // reference model state
  logic [1:0] m_dly0, m_dly1, m_prev;
  int         m_since;
  bit         m_track;
  exp_t       m_out;

  always #5 clk = ~clk;

  quad_decoder #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .qa(qa), .qb(qb), .err_clr(err_clr),
    .step(step), .up_down(up_down), .count(count),
    .err_pulse(err_pulse), .err_flag(err_flag)
  );

  quad_decoder #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .qa(qa), .qb(qb), .err_clr(err_clr),
    .step(step2), .up_down(up_down2), .count(count2),
    .err_pulse(err_pulse2), .err_flag(err_flag2)
  );

  // Position of a phase pair around the forward Gray cycle 00,01,11,10.
  function automatic int ph_idx(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [1:0] seen;
    int         d;
    if (reset) begin
      m_dly0 = 2'b00; m_dly1 = 2'b00; m_prev = 2'b00;
      m_since = 0; m_track = 1'b0;
      m_out = '{step: 1'b0, up_down: 1'b1, count: 8'd0, err_pulse: 1'b0, err_flag: 1'b0};
    end else begin
      seen = m_dly1;
      m_dly1 = m_dly0;
      m_dly0 = {qa, qb};
      m_out.step = 1'b0;
      m_out.err_pulse = 1'b0;
      if (err_clr) m_out.err_flag = 1'b0;
      if (!m_track) begin
        m_since++;
        if (m_since == 3) begin
          m_track = 1'b1;
          m_prev = seen;
        end
      end else begin
        d = (ph_idx(seen) - ph_idx(m_prev) + 4) % 4;
        if (d == 1) begin
          m_out.step = 1'b1; m_out.up_down = 1'b1; m_out.count = m_out.count + 8'd1;
        end else if (d == 3) begin
          m_out.step = 1'b1; m_out.up_down = 1'b0; m_out.count = m_out.count - 8'd1;
        end else if (d == 2) begin
          m_out.err_pulse = 1'b1; m_out.err_flag = 1'b1;
        end
        m_prev = seen;
      end
    end
  endtask

  // Drives one cycle of stimulus, pushes the expectation, compares after the edge.
  task automatic cycle(input logic a, input logic b, input logic r, input logic c);
    exp_t e;
    exp_t act;
    exp_t act2;
    qa = a; qb = b; reset = r; err_clr = c;
    model_edge();
    sb_q.push_back(m_out);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    act = '{step: step, up_down: up_down, count: count, err_pulse: err_pulse, err_flag: err_flag};
    total_cnt++;
    if (act !== e) begin
      $display("FAIL scoreboard_w8 t=%0t got step=%b ud=%b cnt=%h ep=%b ef=%b want step=%b ud=%b cnt=%h ep=%b ef=%b",
               $time, act.step, act.up_down, act.count, act.err_pulse, act.err_flag,
               e.step, e.up_down, e.count, e.err_pulse, e.err_flag);
    end else pass_cnt++;
    act2 = '{step: step2, up_down: up_down2, count: {6'd0, count2}, err_pulse: err_pulse2, err_flag: err_flag2};
    e.count = {6'd0, e.count[1:0]};
    total_cnt++;
    if (act2 !== e) begin
      $display("FAIL scoreboard_w2 t=%0t got step=%b ud=%b cnt=%h ep=%b ef=%b want step=%b ud=%b cnt=%h ep=%b ef=%b",
               $time, act2.step, act2.up_down, act2.count, act2.err_pulse, act2.err_flag,
               e.step, e.up_down, e.count, e.err_pulse, e.err_flag);
    end else pass_cnt++;
  endtask

  task automatic test_reset();
    bit seen_step = 1'b0;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (step === 1'b1) seen_step = 1'b1;
    end
    total_cnt++;
    if ((dut.state_r !== ST_TRACK) || (count !== 8'd0) || seen_step || (up_down !== 1'b1) || (err_flag !== 1'b0)) begin
      $display("FAIL reset_state got st=%0d cnt=%h step_seen=%b ud=%b ef=%b want st=1 cnt=00 step_seen=0 ud=1 ef=0",
               dut.state_r, count, seen_step, up_down, err_flag);
    end else pass_cnt++;
  endtask

  task automatic test_forward();
    logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    int steps = 0;
    int late = 0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 4; j++) begin
          cycle(seq[k][1], seq[k][0], 1'b0, 1'b0);
          if (step === 1'b1) begin
            steps++;
            if (j != 2) late++;
          end
        end
      end
    end
    total_cnt++;
    if ((steps != 8) || (late != 0) || (up_down !== 1'b1) || (count !== 8'd8)) begin
      $display("FAIL forward got steps=%0d mistimed=%0d ud=%b cnt=%h want steps=8 mistimed=0 ud=1 cnt=08",
               steps, late, up_down, count);
    end else pass_cnt++;
  endtask

  task automatic test_reverse();
    logic [1:0] pre [2] = '{2'b10, 2'b00};
    logic [1:0] seq [6] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
    int steps = 0;
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 3; j++) cycle(pre[k][1], pre[k][0], 1'b0, 1'b0);
    total_cnt++;
    if (count !== 8'd2) begin
      $display("FAIL reverse_start got cnt=%h want cnt=02", count);
    end else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 3; j++) begin
        cycle(seq[k][1], seq[k][0], 1'b0, 1'b0);
        if (step === 1'b1) steps++;
      end
    end
    total_cnt++;
    if ((steps != 6) || (up_down !== 1'b0) || (count !== 8'hFC)) begin
      $display("FAIL reverse_wrap got steps=%0d ud=%b cnt=%h want steps=6 ud=0 cnt=fc", steps, up_down, count);
    end else pass_cnt++;
  endtask

  task automatic test_error();
    int pulses = 0;
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    total_cnt++;
    if (pulses != 0) begin
      $display("FAIL init_no_err got pulses=%0d want pulses=0", pulses);
    end else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    total_cnt++;
    if ((pulses != 1) || (err_flag !== 1'b1) || (count !== 8'd0)) begin
      $display("FAIL illegal_jump got pulses=%0d ef=%b cnt=%h want pulses=1 ef=1 cnt=00", pulses, err_flag, count);
    end else pass_cnt++;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    total_cnt++;
    if ((err_pulse !== 1'b1) || (err_flag !== 1'b1)) begin
      $display("FAIL clr_vs_set got ep=%b ef=%b want ep=1 ef=1", err_pulse, err_flag);
    end else pass_cnt++;
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    total_cnt++;
    if ((err_flag !== 1'b0) || (count !== 8'd0)) begin
      $display("FAIL err_clr got ef=%b cnt=%h want ef=0 cnt=00", err_flag, count);
    end else pass_cnt++;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    logic [1:0] seq [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    int steps = 0;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 3; j++) cycle(seq[k][1], seq[k][0], 1'b0, 1'b0);
    total_cnt++;
    if (count !== 8'd5) begin
      $display("FAIL mid_reset_pre got cnt=%h want cnt=05", count);
    end else pass_cnt++;
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if ((count !== 8'd0) || (step !== 1'b0) || (up_down !== 1'b1)) begin
      $display("FAIL mid_reset_edge got cnt=%h step=%b ud=%b want cnt=00 step=0 ud=1", count, step, up_down);
    end else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      if (step === 1'b1) steps++;
    end
    total_cnt++;
    if ((steps != 0) || (count !== 8'd0)) begin
      $display("FAIL mid_reset_init got steps=%0d cnt=%h want steps=0 cnt=00", steps, count);
    end else pass_cnt++;
    for (int j = 0; j < 3; j++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (count !== 8'd1) begin
      $display("FAIL mid_reset_resume got cnt=%h want cnt=01", count);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 2; j++) cycle(seq[k][1], seq[k][0], 1'b0, 1'b0);
    for (int j = 0; j < 2; j++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ((count !== 8'd5) || (err_flag !== 1'b0)) begin
      $display("FAIL back_to_back got cnt=%h ef=%b want cnt=05 ef=0", count, err_flag);
    end else pass_cnt++;
  endtask

  task automatic test_width2();
    logic [1:0] seq [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 3; j++) cycle(seq[k][1], seq[k][0], 1'b0, 1'b0);
      total_cnt++;
      if (count2 !== want[k]) begin
        $display("FAIL width2_step%0d got cnt=%0d want cnt=%0d", k, count2, want[k]);
      end else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_error();
    test_mid_reset();
    test_back_to_back();
    test_width2();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
